axis_burst_framer: RTL

Single-clock AXI-stream burst framer that sits directly downstream of the asynchronous `fifo` read port. It collects words into an internal BURST_LEN-deep buffer, then emits them as one uninterrupted burst with a last-word marker. DMA/accelerator consumers therefore see contiguous bursts and never see FIFO-induced bubbles. An optional idle timeout flushes partially filled bursts.

---
 rtl/axis_burst_framer_if.sv | 12 +
 rtl/axis_burst_framer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/axis_burst_framer_if.sv
// AXI-stream style valid/ready/data bundle used by axis_burst_framer.
// ok = valid & ready; the master holds data stable while valid is high and ready is low.
interface axis_burst_framer_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_burst_framer.sv
// Collects BURST_LEN stream words, then replays them as one gap-free burst with m_last.
// Define BURST_FRAMER_TIMEOUT_EN to flush partial bursts after TIMEOUT_CYC idle cycles.
module axis_burst_framer #(
  parameter int BUFF_WORD   = 32,
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_burst_framer_if.slave   s_stream,
  axis_burst_framer_if.master  m_stream,
  output logic                 m_last,
  output logic                 burst_done,
  output logic                 flush_pulse,
  output logic                 busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int IDX_W = $clog2(BURST_LEN);

  if (BURST_LEN < 2) begin : g_bad_len
    $error("axis_burst_framer: BURST_LEN must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("axis_burst_framer: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_cnt;
  logic [CNT_W-1:0]     len;
  logic                 s_ready;
  logic                 m_valid;
  logic                 s_ok;
  logic                 m_ok;
  logic                 wr_full;
  logic [BUFF_WORD-1:0] buf_mem [BURST_LEN];

`ifdef BURST_FRAMER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              flush_q;
  assign flush_pulse = flush_q;
`else
  assign flush_pulse = 1'b0;
`endif

  assign s_ok    = s_stream.valid & s_ready;
  assign m_ok    = m_valid & m_stream.ready;
  assign wr_full = (wr_cnt == CNT_W'(BURST_LEN - 1));

  // Handshake outputs come straight from flops, so no input reaches them combinationally.
  assign s_stream.ready = s_ready;
  assign m_stream.valid = m_valid;
  assign m_stream.data  = buf_mem[rd_cnt[IDX_W-1:0]];
  assign busy           = (wr_cnt != '0) | (state == DRAIN);

  // NOTE: the word buffer has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (s_ok) buf_mem[wr_cnt[IDX_W-1:0]] <= s_stream.data;
  end

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      len        <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      burst_done <= 1'b0;
`ifdef BURST_FRAMER_TIMEOUT_EN
      idle_cnt   <= '0;
      flush_q    <= 1'b0;
`endif
    end else begin
      burst_done <= 1'b0;
`ifdef BURST_FRAMER_TIMEOUT_EN
      flush_q    <= 1'b0;
`endif
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (s_ok) begin
            wr_cnt <= wr_cnt + 1'b1;
`ifdef BURST_FRAMER_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (wr_full) begin
              len     <= CNT_W'(BURST_LEN);
              rd_cnt  <= '0;
              state   <= DRAIN;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_last  <= 1'b0;
            end
          end
`ifdef BURST_FRAMER_TIMEOUT_EN
          // An accept in the expiry cycle takes the branch above, so it always wins.
          else if (wr_cnt == '0) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
            len      <= wr_cnt;
            rd_cnt   <= '0;
            flush_q  <= 1'b1;
            idle_cnt <= '0;
            state    <= DRAIN;
            s_ready  <= 1'b0;
            m_valid  <= 1'b1;
            m_last   <= (wr_cnt == CNT_W'(1));
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        DRAIN: begin
          if (m_ok) begin
            if (m_last) begin
              rd_cnt     <= '0;
              wr_cnt     <= '0;
              burst_done <= 1'b1;
              state      <= FILL;
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              s_ready    <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              // Look one word ahead so m_last is a flop aligned with the next word.
              m_last <= (rd_cnt == len - CNT_W'(2));
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
